// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronises rx, samples each bit at mid-period and emits
// one-cycle byte / framing-error strobes; a stuck-low line is held off in BREAK.
module uart_rx_byte #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr,
    output logic       rx_busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (CLKS_PER_BIT < 4) begin : g_cpb_check
        $error("uart_rx_byte: CLK_FREQ/BAUD must be at least 4");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       sh_q, sh_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_ferr_q, rx_ferr_d;
    logic             rx_s;

    assign sync_d = {sync_q[0], rx};
    assign rx_s   = sync_q[1];

    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        sh_d       = sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
                if (!rx_s) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (clk_cnt_q == CNT_HALF) begin
                    clk_cnt_d = '0;
                    if (!rx_s) begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end

            S_DATA: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d = '0;
                    sh_d      = {rx_s, sh_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end

            // Leaves mid-stop-bit so a back-to-back start edge is still seen.
            S_STOP: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s) begin
                        rx_data_d  = sh_q;
                        rx_valid_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        rx_ferr_d = 1'b1;
                        state_d   = S_BREAK;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end

            S_BREAK: begin
                clk_cnt_d = '0;
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d   = S_IDLE;
                clk_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            sync_q     <= '1;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            sh_q       <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            sh_q       <= sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_ferr  = rx_ferr_q;
    assign rx_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte: directed scenarios plus random frames,
// judged against a frame-level model (byte in -> strobe out at a fixed latency).
module tb_uart_rx_byte;

    localparam int CPB  = 10;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 3 + HALF + 9 * CPB;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       rx1  = 1'b1;
    logic       rx2  = 1'b1;
    logic [7:0] d1, d2;
    logic       v1, v2, f1, f2, b1, b2;

    uart_rx_byte #(.CLK_FREQ(1_000_000), .BAUD(100_000)) u_dut (
        .clk(clk), .rstn(rstn), .rx(rx1),
        .rx_data(d1), .rx_valid(v1), .rx_ferr(f1), .rx_busy(b1)
    );

    uart_rx_byte #(.CLK_FREQ(3_200_000), .BAUD(100_000)) u_dut_tol (
        .clk(clk), .rstn(rstn), .rx(rx2),
        .rx_data(d2), .rx_valid(v2), .rx_ferr(f2), .rx_busy(b2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Strobe recorder; also enforces exclusivity, single-cycle strobes and data stability.
    logic [7:0] vq1[$];
    int         vc1[$];
    logic [7:0] vq2[$];
    int         ferr1 = 0;
    int         ferr2 = 0;
    logic       pv1 = 1'b0;
    logic       pf1 = 1'b0;
    logic [7:0] pd1 = 8'h00;

    always @(negedge clk) begin
        if (v1) begin
            vq1.push_back(d1);
            vc1.push_back(cyc);
        end
        if (f1) ferr1++;
        if (v2) vq2.push_back(d2);
        if (f2) ferr2++;
        if (rstn) begin
            if (v1 | f1) chk("valid_ferr_excl", 32'(v1 & f1), 32'd0);
            if (v1) chk("valid_one_cycle", 32'(pv1), 32'd0);
            if (f1) chk("ferr_one_cycle", 32'(pf1), 32'd0);
            if (!v1) chk("data_stable", 32'(d1), 32'(pd1));
        end
        pv1 <= v1;
        pf1 <= f1;
        pd1 <= d1;
    end

    int         last_fall = 0;
    logic [7:0] last_good = 8'h00;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int line, input logic v);
        if (line == 1) rx1 = v;
        else rx2 = v;
    endtask

    task automatic send(input int line, input logic [7:0] b, input int per, input logic stop);
        logic [9:0] bits;
        bits      = {stop, b, 1'b0};
        last_fall = cyc;
        for (int i = 0; i < 10; i++) begin
            drive(line, bits[i]);
            tick(per);
        end
    endtask

    task automatic expect_good(input logic [7:0] b, input int n0, input string tag);
        int d;
        chk({tag, "_count"}, 32'(vq1.size()), 32'(n0 + 1));
        if (vq1.size() > n0) begin
            chk({tag, "_byte"}, 32'(vq1[n0]), 32'(b));
            d = vc1[n0] - last_fall;
            chk({tag, "_latency"}, (d >= LAT - 1 && d <= LAT + 1) ? 32'(LAT) : 32'(d), 32'(LAT));
        end
        chk({tag, "_rx_data"}, 32'(d1), 32'(b));
        last_good = b;
    endtask

    initial begin
        int         n0;
        int         f0;
        int         gap;
        logic [7:0] b;
        logic       ok;
        logic [7:0] prior;
        logic [31:0] word;

        tick(3);
        chk("rst_data", 32'(d1), 32'd0);
        chk("rst_valid", 32'(v1), 32'd0);
        chk("rst_ferr", 32'(f1), 32'd0);
        chk("rst_busy", 32'(b1), 32'd0);
        rstn = 1'b1;
        tick(5);

        n0 = vq1.size();
        f0 = ferr1;
        send(1, 8'hA5, CPB, 1'b1);
        expect_good(8'hA5, n0, "single");
        chk("single_no_ferr", 32'(ferr1), 32'(f0));
        chk("single_busy_low", 32'(b1), 32'd0);
        tick(5);

        // Back-to-back frames, no idle bits, packed MSB-first like the loader.
        n0 = vq1.size();
        send(1, 8'h00, CPB, 1'b1);
        send(1, 8'h00, CPB, 1'b1);
        send(1, 8'h00, CPB, 1'b1);
        send(1, 8'h13, CPB, 1'b1);
        chk("b2b_count", 32'(vq1.size()), 32'(n0 + 4));
        if (vq1.size() >= n0 + 4) begin
            word = {vq1[n0], vq1[n0+1], vq1[n0+2], vq1[n0+3]};
            chk("b2b_word", word, 32'h0000_0013);
            for (int k = 1; k < 4; k++) begin
                int sp;
                sp = vc1[n0+k] - vc1[n0+k-1];
                chk("b2b_spacing", (sp >= 99 && sp <= 101) ? 32'd100 : 32'(sp), 32'd100);
            end
        end
        last_good = 8'h13;
        tick(5);

        n0 = vq1.size();
        f0 = ferr1;
        drive(1, 1'b0);
        tick(3);
        drive(1, 1'b1);
        tick(12);
        chk("glitch_busy", 32'(b1), 32'd0);
        chk("glitch_no_valid", 32'(vq1.size()), 32'(n0));
        chk("glitch_no_ferr", 32'(ferr1), 32'(f0));
        send(1, 8'h3C, CPB, 1'b1);
        expect_good(8'h3C, n0, "post_glitch");
        tick(5);

        n0    = vq1.size();
        f0    = ferr1;
        prior = last_good;
        send(1, 8'h77, CPB, 1'b0);
        tick(15 * CPB);
        chk("break_busy_mid", 32'(b1), 32'd1);
        tick(15 * CPB);
        chk("break_ferr_once", 32'(ferr1), 32'(f0 + 1));
        chk("break_no_valid", 32'(vq1.size()), 32'(n0));
        chk("break_data_kept", 32'(d1), 32'(prior));
        chk("break_busy_end", 32'(b1), 32'd1);
        drive(1, 1'b1);
        tick(4);
        chk("break_busy_idle", 32'(b1), 32'd0);
        tick(3);
        send(1, 8'h5A, CPB, 1'b1);
        expect_good(8'h5A, n0, "post_break");
        tick(5);

        // Abort during bit 4 of 0xFF.
        n0 = vq1.size();
        drive(1, 1'b0);
        tick(CPB);
        drive(1, 1'b1);
        tick(4 * CPB + HALF);
        rstn = 1'b0;
        #1;
        chk("abort_data", 32'(d1), 32'd0);
        chk("abort_valid", 32'(v1), 32'd0);
        chk("abort_ferr", 32'(f1), 32'd0);
        chk("abort_busy", 32'(b1), 32'd0);
        tick(3);
        rstn = 1'b1;
        tick(5);
        send(1, 8'h81, CPB, 1'b1);
        expect_good(8'h81, n0, "post_abort");
        tick(20);
        chk("post_abort_single", 32'(vq1.size()), 32'(n0 + 1));

        for (int it = 0; it < 24; it++) begin
            b   = 8'($urandom_range(0, 255));
            ok  = ($urandom_range(0, 5) != 0);
            gap = $urandom_range(0, 8);
            n0  = vq1.size();
            f0  = ferr1;
            send(1, b, CPB, ok);
            if (ok) begin
                expect_good(b, n0, "rnd");
                chk("rnd_no_ferr", 32'(ferr1), 32'(f0));
            end else begin
                tick($urandom_range(1, 40));
                chk("rnd_ferr", 32'(ferr1), 32'(f0 + 1));
                chk("rnd_ferr_no_valid", 32'(vq1.size()), 32'(n0));
                chk("rnd_ferr_data_kept", 32'(d1), 32'(last_good));
                drive(1, 1'b1);
                tick(2);
            end
            tick(gap);
        end

        // Baud mismatch on the 32 clk/bit instance.
        send(2, 8'h55, 31, 1'b1);
        send(2, 8'hAA, 33, 1'b1);
        tick(10);
        chk("tol_count", 32'(vq2.size()), 32'd2);
        if (vq2.size() >= 2) begin
            chk("tol_byte_fast", 32'(vq2[0]), 32'h55);
            chk("tol_byte_slow", 32'(vq2[1]), 32'hAA);
        end
        chk("tol_no_ferr", 32'(ferr2), 32'd0);
        chk("tol_busy", 32'(b2), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
